// File: rtl/sprite_bus_arbiter_if.sv
// Sprite mux bus: per-channel request/last lines in, one-hot select and
// handshake status out. The arbiter takes the master modport.
interface sprite_bus_arbiter_if;
    logic [15:0] req;
    logic [15:0] last;
    logic        sink_ready;
    logic [15:0] select;
    logic        bus_valid;
    logic [15:0] beat_ack;
    logic [3:0]  owner;
    logic        busy;

    modport master (
        input  req, last, sink_ready,
        output select, bus_valid, beat_ack, owner, busy
    );

    modport slave (
        output req, last, sink_ready,
        input  select, bus_valid, beat_ack, owner, busy
    );
endinterface

// File: rtl/sprite_bus_arbiter.sv
// Round-robin arbiter for the 16-channel one-hot sprite mux. A grant always
// passes through IDLE, so select never jumps between two channels and the
// OR-based mux never sees two select bits at once.
module sprite_bus_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    sprite_bus_arbiter_if.master bus
);
    localparam int              NUM_CH  = 16;
    localparam logic [0:0]      S_IDLE  = 1'b0;
    localparam logic [0:0]      S_GRANT = 1'b1;
    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_BURST);

    logic [0:0]       r_state;
    logic [15:0]      r_select;
    logic [3:0]       r_owner;
    logic [3:0]       r_rr_ptr;
    logic [CNT_W-1:0] r_beat_cnt;

    logic             w_grant;
    logic             w_req_own;
    logic             w_bus_valid;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_release;
    logic             w_found;
    logic [3:0]       w_win;

    // Owner-side handshake; an ack is suppressed while reset is asserted
    // so a burst cut by reset never reports a beat it did not finish.
    always_comb begin
        w_grant     = (r_state == S_GRANT);
        w_req_own   = bus.req[r_owner];
        w_bus_valid = w_grant & w_req_own;
        w_accept    = w_bus_valid & bus.sink_ready & ~i_reset;
        w_cnt_nxt   = r_beat_cnt + 1'b1;
        w_release   = w_grant & (~w_req_own |
                      (w_accept & (bus.last[r_owner] | (w_cnt_nxt == LP_MAX))));
    end

    // Round-robin search: first requesting channel at or above rr_ptr, wrapping.
    always_comb begin
        logic [3:0] v_idx;
        w_found = 1'b0;
        w_win   = 4'd0;
        v_idx   = 4'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            v_idx = r_rr_ptr + 4'(i);
            if (!w_found && bus.req[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    // Grant/release sequencing and beat counting.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_select   <= 16'd0;
            r_owner    <= 4'd0;
            r_rr_ptr   <= 4'd0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_GRANT;
                        r_select   <= 16'd1 << w_win;
                        r_owner    <= w_win;
                        r_beat_cnt <= '0;
                    end
                end
                default: begin
                    if (w_release) begin
                        r_state  <= S_IDLE;
                        r_select <= 16'd0;
                        r_rr_ptr <= r_owner + 4'd1;
                    end
                    if (w_accept) r_beat_cnt <= w_cnt_nxt;
                end
            endcase
        end
    end

    // Registered grant drives the mux select directly; acks mirror it.
    always_comb begin
        bus.select    = r_select;
        bus.owner     = r_owner;
        bus.busy      = w_grant;
        bus.bus_valid = w_bus_valid;
        bus.beat_ack  = r_select & {16{w_accept}};
    end
endmodule

// File: tb/tb_sprite_bus_arbiter.sv
// Directed bench for sprite_bus_arbiter: a transaction-level model predicts
// every output each cycle; literal expectations pin the key scenarios.
module tb_sprite_bus_arbiter;
    localparam int MAXB = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_bus_arbiter_if bus ();

    sprite_bus_arbiter #(.MAX_BURST(MAXB)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus, how many beats it has had, where the search starts.
    bit m_valid = 0;
    bit m_busy;
    int m_owner, m_ptr, m_cnt;

    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            m_valid = 1; m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_valid) begin
            if (!m_busy) begin
                for (int k = 0; k < 16; k++) begin
                    if (bus.req[(m_ptr + k) % 16]) begin
                        m_owner = (m_ptr + k) % 16;
                        m_busy = 1; m_cnt = 0;
                        break;
                    end
                end
            end else begin
                acc = bus.req[m_owner] && bus.sink_ready;
                if (!bus.req[m_owner]) begin
                    m_busy = 0; m_ptr = (m_owner + 1) % 16;
                end else if (acc) begin
                    m_cnt++;
                    if (bus.last[m_owner] || m_cnt == MAXB) begin
                        m_busy = 0; m_ptr = (m_owner + 1) % 16;
                    end
                end
            end
        end
    end

    // Per-cycle compare plus DUT-side observation log.
    int          dut_acks[16];
    int          dut_grants[$];
    logic [15:0] prev_sel = 16'd0;

    always @(negedge clk) begin
        logic [15:0] e_sel, e_ack;
        logic        e_bv;
        if (m_valid) begin
            e_sel = m_busy ? (16'd1 << m_owner) : 16'd0;
            e_bv  = m_busy && bus.req[m_owner];
            e_ack = (e_bv && bus.sink_ready && !reset) ? e_sel : 16'd0;
            chk("select",    32'(bus.select),    32'(e_sel));
            chk("bus_valid", 32'(bus.bus_valid), 32'(e_bv));
            chk("beat_ack",  32'(bus.beat_ack),  32'(e_ack));
            chk("busy",      32'(bus.busy),      32'(m_busy));
            chk("owner",     32'(bus.owner),     32'(m_owner));
            chk("onehot0",   32'($onehot0(bus.select)), 32'd1);
        end
        for (int c = 0; c < 16; c++) if (bus.beat_ack[c]) dut_acks[c]++;
        if (bus.select != 16'd0 && prev_sel == 16'd0) dut_grants.push_back(int'(bus.owner));
        prev_sel = bus.select;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        for (int c = 0; c < 16; c++) dut_acks[c] = 0;
        dut_grants.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.req = 16'd0; bus.last = 16'd0; bus.sink_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        clear_log();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = 16'd0; bus.last = 16'd0; bus.sink_ready = 1'b0;
        // 1: single 3-beat burst on ch0
        do_reset();
        chk("t1_reset_sel",  32'(bus.select), 32'h0);
        chk("t1_reset_busy", 32'(bus.busy),   32'h0);
        bus.req = 16'h0001;
        tick();
        chk("t1_grant_sel", 32'(bus.select), 32'h0001);
        tick(); tick();
        bus.last = 16'h0001;
        tick();
        chk("t1_rel_sel",  32'(bus.select), 32'h0);
        chk("t1_rel_busy", 32'(bus.busy),   32'h0);
        chk("t1_acks",     32'(dut_acks[0]), 32'd3);
        bus.req = 16'd0; bus.last = 16'd0;
        tick();

        // 2: all channels, one beat each, rotating
        do_reset();
        bus.req = 16'hFFFF; bus.last = 16'hFFFF;
        repeat (34) tick();
        bus.req = 16'd0; bus.last = 16'd0;
        tick();
        chk("t2_ngrants", 32'(dut_grants.size()), 32'd17);
        for (int g = 0; g < 17 && g < dut_grants.size(); g++)
            chk("t2_order", 32'(dut_grants[g]), 32'(g % 16));
        chk("t2_ack0", 32'(dut_acks[0]), 32'd2);
        chk("t2_ack9", 32'(dut_acks[9]), 32'd1);

        // 3: burst limit on ch5, then re-grant after one IDLE cycle
        do_reset();
        bus.req = 16'h0020;
        tick();
        repeat (8) tick();
        chk("t3_rel_sel", 32'(bus.select), 32'h0);
        chk("t3_acks",    32'(dut_acks[5]), 32'd8);
        tick();
        chk("t3_regrant", 32'(bus.select), 32'h0020);
        bus.req = 16'd0;
        tick(); tick();

        // 4: stall mid-burst on ch2
        do_reset();
        bus.req = 16'h0004;
        tick(); tick(); tick();
        bus.sink_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t4_stall_sel", 32'(bus.select),    32'h0004);
            chk("t4_stall_bv",  32'(bus.bus_valid), 32'h1);
            chk("t4_stall_ack", 32'(bus.beat_ack),  32'h0);
            tick();
        end
        chk("t4_acks_held", 32'(dut_acks[2]), 32'd2);
        bus.sink_ready = 1'b1; bus.last = 16'h0004;
        tick();
        chk("t4_rel_sel", 32'(bus.select),  32'h0);
        chk("t4_acks",    32'(dut_acks[2]), 32'd3);
        bus.req = 16'd0; bus.last = 16'd0;
        tick();

        // 5: abort on ch3 with ch0 pending
        do_reset();
        bus.req = 16'h0008;
        tick(); tick(); tick();
        bus.req = 16'h0001;
        @(negedge clk);
        chk("t5_abort_bv",  32'(bus.bus_valid), 32'h0);
        chk("t5_abort_ack", 32'(bus.beat_ack),  32'h0);
        tick();
        chk("t5_rel_sel", 32'(bus.select), 32'h0);
        tick();
        chk("t5_next_sel",   32'(bus.select), 32'h0001);
        chk("t5_next_owner", 32'(bus.owner),  32'h0);
        chk("t5_acks",       32'(dut_acks[3]), 32'd2);
        bus.req = 16'd0;
        tick(); tick();

        // 6: reset during the 2nd beat of a ch7 burst
        do_reset();
        bus.req = 16'h0080;
        tick(); tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_ack", 32'(bus.beat_ack), 32'h0);
        tick();
        chk("t6_sel",   32'(bus.select), 32'h0);
        chk("t6_busy",  32'(bus.busy),   32'h0);
        chk("t6_owner", 32'(bus.owner),  32'h0);
        reset = 1'b0; bus.req = 16'h0081;
        tick();
        chk("t6_regrant_sel",   32'(bus.select), 32'h0001);
        chk("t6_regrant_owner", 32'(bus.owner),  32'h0);
        chk("t6_acks7",         32'(dut_acks[7]), 32'd1);
        bus.req = 16'd0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
